// File: rtl/mailbox_pkg.sv
// Shared types and constants for the test mailbox.
// Register offsets, state encoding, finish magic and STATUS bits.
package mailbox_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam logic [2:0] OFF_EXPECT  = 3'd0;
  localparam logic [2:0] OFF_RESULT  = 3'd1;
  localparam logic [2:0] OFF_CONTROL = 3'd2;
  localparam logic [2:0] OFF_STATUS  = 3'd3;
  localparam logic [2:0] OFF_FAILCNT = 3'd4;

  localparam logic [7:0] FINISH_MAGIC = 8'hA5;

  localparam int STATUS_DONE    = 7;
  localparam int STATUS_PASS    = 6;
  localparam int STATUS_TIMEOUT = 5;

endpackage

// File: rtl/test_mailbox_if.sv
// CPU data-bus view of the mailbox register window.
// first_bad carries the first mismatching RESULT for trace output.
interface test_mailbox_if;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic        memwrite;
  logic        memread;
  logic [7:0]  rdata;
  logic [7:0]  first_bad;

  modport master (
    output address, wdata, memwrite, memread,
    input  rdata, first_bad
  );

  modport slave (
    input  address, wdata, memwrite, memread,
    output rdata, first_bad
  );
endinterface

// File: rtl/mailbox_watchdog.sv
// Saturating RUN-cycle counter and budget compare.
// expired is raw; the top qualifies it with state and build option.
module mailbox_watchdog #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic             ph1,
  input  logic             reset,
  input  logic             run,
  output logic [CNT_W-1:0] cycles,
  output logic             expired
);

  always_ff @(posedge ph1) begin
    if (reset)
      cycles <= '0;
    else if (run && (cycles != '1))
      cycles <= cycles + 1'b1;
  end

  assign expired = (cycles == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/test_mailbox.sv
// Self-checking test ROM verdict mailbox on the CPU data bus.
// Define MAILBOX_WATCHDOG_EN to enable the TIMEOUT verdict.
module test_mailbox
  import mailbox_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR      = 16'hFFF0,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          CNT_W          = 16
) (
  input  logic             ph1,
  input  logic             reset,
  test_mailbox_if.slave    bus,
  output logic             done,
  output logic             pass,
  output logic [7:0]       fail_count,
  output logic [CNT_W-1:0] cycles
);

  state_t      state_q, state_d;
  logic [15:0] delta;
  logic [2:0]  off;
  logic        hit, wr, mism, fin;
  logic        expired, tmo_hit, run, tmo;
  logic [7:0]  expect_q, bad_q, rdata_q;
  logic [7:0]  fc_d, rd_d, status_v;

  // Subtracting the base keeps the window correct for unaligned bases.
  assign delta = bus.address - BASE_ADDR;
  assign hit   = (delta[15:3] == 13'd0);
  assign off   = delta[2:0];

  assign wr   = bus.memwrite && hit && (state_q == ST_RUN);
  assign mism = wr && (off == OFF_RESULT) && (bus.wdata != expect_q);
  assign fin  = wr && (off == OFF_CONTROL)
             && (bus.wdata == FINISH_MAGIC);

  assign fc_d = (mism && (fail_count != 8'hFF))
              ? fail_count + 8'd1 : fail_count;

`ifdef MAILBOX_WATCHDOG_EN
  assign tmo_hit = expired && (state_q == ST_RUN);
`else
  assign tmo_hit = expired & 1'b0;
`endif

  // Count only cycles that stay in RUN, so the leaving edge freezes it.
  assign run = (state_q == ST_RUN) && (state_d == ST_RUN);

  mailbox_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_wdog (
    .ph1    (ph1),
    .reset  (reset),
    .run    (run),
    .cycles (cycles),
    .expired(expired)
  );

  always_ff @(posedge ph1) begin
    if (reset)
      state_q <= ST_RUN;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (fin)
        state_d = (fc_d == 8'd0) ? ST_PASS : ST_FAIL;
      else if (tmo_hit)
        state_d = ST_TIMEOUT;
    end
  end

  always_comb begin
    done = (state_q != ST_RUN);
    pass = (state_q == ST_PASS);
    tmo  = (state_q == ST_TIMEOUT);
  end

  always_comb begin
    status_v                 = 8'h00;
    status_v[STATUS_DONE]    = done;
    status_v[STATUS_PASS]    = pass;
    status_v[STATUS_TIMEOUT] = tmo;
    status_v[1:0]            = state_q;
  end

  always_comb begin
    rd_d = 8'h00;
    unique case (1'b1)
      off == OFF_EXPECT:  rd_d = expect_q;
      off == OFF_STATUS:  rd_d = status_v;
      off == OFF_FAILCNT: rd_d = fail_count;
      default:            rd_d = 8'h00;
    endcase
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      expect_q   <= 8'h00;
      fail_count <= 8'h00;
      bad_q      <= 8'h00;
      rdata_q    <= 8'h00;
    end else begin
      if (wr && (off == OFF_EXPECT))
        expect_q <= bus.wdata;
      if (mism && (fail_count == 8'h00))
        bad_q <= bus.wdata;
      fail_count <= fc_d;
      if (bus.memread && hit)
        rdata_q <= rd_d;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.first_bad = bad_q;

endmodule

// File: tb/tb_test_mailbox.sv
// Scoreboard bench for test_mailbox.
// Build with MAILBOX_WATCHDOG_EN to exercise the 20-cycle timeout.
module tb_test_mailbox;
  import mailbox_pkg::*;

`ifdef MAILBOX_WATCHDOG_EN
  localparam int TO = 20;
`else
  localparam int TO = 1000;
`endif
  localparam logic [15:0] BASE = 16'hFFF0;

  logic        ph1;
  logic        reset;
  logic        done, pass;
  logic [7:0]  fail_count;
  logic [15:0] cycles;
  logic [7:0]  exp_q[$];
  logic [7:0]  got, want;
  int          n_cmp, n_bad;

  test_mailbox_if bus();

  test_mailbox #(
    .BASE_ADDR     (BASE),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (16)
  ) dut (
    .ph1       (ph1),
    .reset     (reset),
    .bus       (bus.slave),
    .done      (done),
    .pass      (pass),
    .fail_count(fail_count),
    .cycles    (cycles)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  task automatic do_reset();
    @(negedge ph1);
    reset = 1'b1;
    @(negedge ph1);
    reset = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge ph1);
    bus.address  = a;
    bus.wdata    = d;
    bus.memwrite = 1'b1;
    @(negedge ph1);
    bus.memwrite = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    @(negedge ph1);
    bus.address = a;
    bus.memread = 1'b1;
    @(negedge ph1);
    bus.memread = 1'b0;
    d = bus.rdata;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({done, pass, fail_count, cycles, bus.rdata} !== 34'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {done, pass, fail_count, cycles, bus.rdata});
    end
    exp_q.push_back(8'h00);
    rd(BASE, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL reset_expect: got %h want %h", got, want);
    end
  endtask

  task automatic test_pass();
    do_reset();
    wr(BASE, 8'h6E);
    wr(BASE + 16'd1, 8'h6E);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL pass_pre_done: got %b want 0", done);
    end
    wr(BASE + 16'd2, 8'hA5);
    n_cmp++;
    if ({done, pass, fail_count} !== {2'b11, 8'h00}) begin
      n_bad++;
      $display("FAIL pass_verdict: got %b%b %h want 11 00",
               done, pass, fail_count);
    end
    exp_q.push_back(8'hC1);
    rd(BASE + 16'd3, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL pass_status: got %h want %h", got, want);
    end
  endtask

  task automatic test_fail_sat();
    logic [7:0] mfc;
    logic [7:0] v;
    mfc = 8'h00;
    do_reset();
    wr(BASE, 8'h6E);
    for (int i = 0; i < 300; i++) begin
      v = (i == 0) ? 8'h6F : 8'($urandom_range(0, 255));
      if (v == 8'h6E) v = 8'h6F;
      if (mfc != 8'hFF) mfc = mfc + 8'd1;
      wr(BASE + 16'd1, v);
      if (i == 9) begin
        n_cmp++;
        if (fail_count !== mfc) begin
          n_bad++;
          $display("FAIL fail_mid_count: got %h want %h",
                   fail_count, mfc);
        end
      end
    end
    exp_q.push_back(mfc);
    wr(BASE + 16'd2, 8'hA5);
    got  = fail_count;
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL fail_sat_count: got %h want %h", got, want);
    end
    n_cmp++;
    if ({done, pass} !== 2'b10) begin
      n_bad++;
      $display("FAIL fail_verdict: got %b%b want 10", done, pass);
    end
    n_cmp++;
    if (bus.first_bad !== 8'h6F) begin
      n_bad++;
      $display("FAIL fail_first_bad: got %h want 6f", bus.first_bad);
    end
    exp_q.push_back(8'h82);
    rd(BASE + 16'd3, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL fail_status: got %h want %h", got, want);
    end
  endtask

  task automatic test_bad_magic();
    do_reset();
    wr(BASE + 16'd2, 8'h00);
    exp_q.push_back(8'h00);
    rd(BASE + 16'd3, got);
    want = exp_q.pop_front();
    n_cmp++;
    if ({done, got} !== {1'b0, want}) begin
      n_bad++;
      $display("FAIL magic_ignored: got %b %h want 0 %h",
               done, got, want);
    end
    wr(BASE + 16'd2, 8'hA5);
    n_cmp++;
    if ({done, pass} !== 2'b11) begin
      n_bad++;
      $display("FAIL magic_pass: got %b%b want 11", done, pass);
    end
    wr(BASE, 8'h11);
    wr(BASE + 16'd1, 8'h22);
    wr(BASE + 16'd2, 8'h33);
    n_cmp++;
    if ({pass, fail_count} !== {1'b1, 8'h00}) begin
      n_bad++;
      $display("FAIL sticky_pass: got %b %h want 1 00",
               pass, fail_count);
    end
    exp_q.push_back(8'h00);
    rd(BASE, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL sticky_expect: got %h want %h", got, want);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
`ifdef MAILBOX_WATCHDOG_EN
    repeat (19) @(negedge ph1);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL wdog_early: got %b want 0", done);
    end
    @(negedge ph1);
    n_cmp++;
    if ({done, pass, cycles} !== {2'b10, 16'd19}) begin
      n_bad++;
      $display("FAIL wdog_fire: got %b%b %0d want 10 19",
               done, pass, cycles);
    end
    exp_q.push_back(8'hA3);
    rd(BASE + 16'd3, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL wdog_status: got %h want %h", got, want);
    end
    n_cmp++;
    if (cycles !== 16'd19) begin
      n_bad++;
      $display("FAIL wdog_frozen: got %0d want 19", cycles);
    end
`else
    repeat (100) @(negedge ph1);
    n_cmp++;
    if ({done, cycles} !== {1'b0, 16'd100}) begin
      n_bad++;
      $display("FAIL nowdog_count: got %b %0d want 0 100",
               done, cycles);
    end
    exp_q.push_back(8'h00);
    rd(BASE + 16'd3, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL nowdog_status: got %h want %h", got, want);
    end
`endif
  endtask

  task automatic test_read_reset();
    do_reset();
    wr(BASE, 8'h5A);
    exp_q.push_back(8'h00);
    rd(BASE + 16'd6, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL read_off6: got %h want %h", got, want);
    end
    exp_q.push_back(8'h5A);
    rd(BASE, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL read_expect: got %h want %h", got, want);
    end
    exp_q.push_back(8'h5A);
    rd(BASE + 16'd8, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL read_outside_hold: got %h want %h", got, want);
    end
    wr(BASE - 16'd1, 8'hA5);
    wr(BASE + 16'd1, 8'h00);
    n_cmp++;
    if ({done, fail_count} !== {1'b0, 8'h01}) begin
      n_bad++;
      $display("FAIL outside_write: got %b %h want 0 01",
               done, fail_count);
    end
    @(negedge ph1);
    reset = 1'b1;
    @(negedge ph1);
    n_cmp++;
    if ({done, pass, fail_count, cycles, bus.rdata} !== 34'd0) begin
      n_bad++;
      $display("FAIL midrun_reset: got %h want 0",
               {done, pass, fail_count, cycles, bus.rdata});
    end
    reset = 1'b0;
    exp_q.push_back(8'h00);
    rd(BASE, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL reset_clears_expect: got %h want %h", got, want);
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    reset        = 1'b1;
    bus.address  = 16'h0000;
    bus.wdata    = 8'h00;
    bus.memwrite = 1'b0;
    bus.memread  = 1'b0;
    test_reset();
    test_pass();
`ifndef MAILBOX_WATCHDOG_EN
    test_fail_sat();
    test_bad_magic();
`endif
    test_watchdog();
    test_read_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
